// File: rtl/hex_operand_entry.sv
// -----------------------------------------------------------------------------
// hex_operand_entry
//
// Purpose:
//   Collects two hex operands from a stream of 4-bit key codes and hands them
//   to the adder FSM. Digits shift into a shadow register. Each ENTER commits
//   one operand: the first goes to num1_hex, the second to num2_hex. Once both
//   are committed, operands_valid stays high until the consumer acks.
//   If half-typed entry sits idle too long, it is aborted.
//
// Parameters:
//   DIGITS   hex digits per operand (W = 4*DIGITS)
//   TIMEOUT  idle cycles before a pending entry is aborted; 0 disables it
//
// Ports:
//   clk, rst        clock (rising edge); asynchronous active-high reset
//   key_valid       1-cycle strobe, key_code holds a digit
//   key_code [3:0]  hex digit
//   key_enter       1-cycle strobe, commit the current operand
//   key_clear       1-cycle strobe, abort and clear everything
//   operands_ack    consumer has taken the operands (honoured only in HOLD)
//   num1_hex [W]    committed operand 1
//   num2_hex [W]    committed operand 2
//   operands_valid  both operands committed, held until ack
//   shadow_hex [W]  digits typed so far, for the live display
//   digit_count     number of digits in the shadow, 0..DIGITS
//   entry_state [2] 00 ENTRY1, 01 ENTRY2, 10 HOLD (also the FSM debug view)
//   overflow        1-cycle pulse: a digit was dropped because the shadow was full
//
// Handshake: each key_* input is a single-cycle strobe that is sampled on a
// rising clk edge. Its effect shows on the registered outputs after that edge.
// operands_valid rises on the edge that commits operand 2. It falls on the
// first edge where operands_ack is seen high in HOLD.
// -----------------------------------------------------------------------------
module hex_operand_entry #(
  parameter int DIGITS  = 3,
  parameter int TIMEOUT = 50000000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               key_valid,
  input  logic [3:0]                         key_code,
  input  logic                               key_enter,
  input  logic                               key_clear,
  input  logic                               operands_ack,
  output logic [4*DIGITS-1:0]                num1_hex,
  output logic [4*DIGITS-1:0]                num2_hex,
  output logic                               operands_valid,
  output logic [4*DIGITS-1:0]                shadow_hex,
  output logic [$clog2(DIGITS+1)-1:0]        digit_count,
  output logic [1:0]                         entry_state,
  output logic                               overflow
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  // The idle counter only has to reach TIMEOUT-1.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] IDLE_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DIGITS);

  typedef enum logic [1:0] {
    ST_ENTRY1 = 2'b00,
    ST_ENTRY2 = 2'b01,
    ST_HOLD   = 2'b10
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_shadow;
  logic [CW-1:0]   r_count;
  logic [W-1:0]    r_num1;
  logic [W-1:0]    r_num2;
  logic            r_valid;
  logic            r_overflow;
  logic [TW-1:0]   r_idle;

  logic            w_pending;
  logic            w_timeout;
  logic            w_full;
  logic [W-1:0]    w_shift_in;

  // Entry counts as pending when digits are sitting in the shadow, or when
  // operand 1 is committed and we are waiting on operand 2.
  assign w_pending  = ((r_state == ST_ENTRY1) && (r_count != '0)) ||
                      (r_state == ST_ENTRY2);
  assign w_timeout  = (TIMEOUT != 0) && w_pending && (r_idle == IDLE_LAST);
  assign w_full     = (r_count == COUNT_FULL);
  // A shift plus OR (rather than a part-select) keeps DIGITS=1 legal.
  assign w_shift_in = (r_shadow << 4) | W'(key_code);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_ENTRY1;
      r_shadow   <= '0;
      r_count    <= '0;
      r_num1     <= '0;
      r_num2     <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
      r_idle     <= '0;
    end else begin
      r_overflow <= 1'b0;
      if (key_clear || w_timeout) begin
        // A clear takes priority over everything. A timeout does the same
        // thing. Any digit or enter arriving in this cycle is dropped.
        r_state  <= ST_ENTRY1;
        r_shadow <= '0;
        r_count  <= '0;
        r_num1   <= '0;
        r_num2   <= '0;
        r_valid  <= 1'b0;
        r_idle   <= '0;
      end else begin
        case (r_state)
          ST_ENTRY1, ST_ENTRY2: begin
            if (key_enter) begin
              // A digit in the same cycle as enter is discarded.
              if (r_state == ST_ENTRY1) begin
                r_num1  <= r_shadow;
                r_state <= ST_ENTRY2;
              end else begin
                r_num2  <= r_shadow;
                r_valid <= 1'b1;
                r_state <= ST_HOLD;
              end
              r_shadow <= '0;
              r_count  <= '0;
            end else if (key_valid) begin
              if (!w_full) begin
                r_shadow <= w_shift_in;
                r_count  <= r_count + CW'(1);
              end else begin
                r_overflow <= 1'b1;
              end
            end
            if (key_valid || key_enter) begin
              r_idle <= '0;
            end else if (w_pending) begin
              r_idle <= r_idle + TW'(1);
            end else begin
              r_idle <= '0;
            end
          end
          ST_HOLD: begin
            // Keys are ignored while the consumer owns the operands.
            if (operands_ack) begin
              r_valid <= 1'b0;
              r_state <= ST_ENTRY1;
            end
            r_idle <= '0;
          end
          default: begin
            // Unreachable encoding: fall back to a clean start.
            r_state  <= ST_ENTRY1;
            r_shadow <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_idle   <= '0;
          end
        endcase
      end
    end
  end

  assign num1_hex       = r_num1;
  assign num2_hex       = r_num2;
  assign operands_valid = r_valid;
  assign shadow_hex     = r_shadow;
  assign digit_count    = r_count;
  assign entry_state    = r_state;
  assign overflow       = r_overflow;

endmodule

// File: tb/tb_hex_operand_entry.sv
module tb_hex_operand_entry;

  localparam int D  = 3;
  localparam int T  = 8;
  localparam int W  = 4 * D;
  localparam int CW = $clog2(D + 1);

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          key_valid, key_enter, key_clear, operands_ack;
  logic [3:0]    key_code;
  logic [W-1:0]  num1_hex, num2_hex, shadow_hex;
  logic          operands_valid, overflow;
  logic [CW-1:0] digit_count;
  logic [1:0]    entry_state;

  always #5 clk = ~clk;

  hex_operand_entry #(.DIGITS(D), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .key_valid(key_valid), .key_code(key_code),
    .key_enter(key_enter), .key_clear(key_clear),
    .operands_ack(operands_ack),
    .num1_hex(num1_hex), .num2_hex(num2_hex),
    .operands_valid(operands_valid), .shadow_hex(shadow_hex),
    .digit_count(digit_count), .entry_state(entry_state),
    .overflow(overflow)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // The operand is tracked as a number. A digit entry is value*16 + digit,
  // kept to D hex digits. phase: 0 = typing operand 1, 1 = typing operand 2,
  // 2 = waiting for ack. idle counts consecutive strobe-free cycles.
  int m_phase, m_val, m_ndig, m_n1, m_n2, m_valid, m_ovf, m_idle;

  task automatic model_wipe();
    m_phase = 0; m_val = 0; m_ndig = 0; m_n1 = 0; m_n2 = 0;
    m_valid = 0; m_idle = 0;
  endtask

  task automatic model_step(input bit kv, input int code, input bit ke,
                            input bit kc, input bit ack);
    bit waiting;
    waiting = (m_phase == 1) || (m_phase == 0 && m_ndig > 0);
    m_ovf = 0;
    if (kc || (waiting && m_idle == T - 1)) begin
      model_wipe();
    end else if (m_phase == 2) begin
      if (ack) begin
        m_valid = 0;
        m_phase = 0;
      end
      m_idle = 0;
    end else begin
      if (ke) begin
        if (m_phase == 0) m_n1 = m_val;
        else begin
          m_n2 = m_val;
          m_valid = 1;
        end
        m_phase = m_phase + 1;
        m_val = 0;
        m_ndig = 0;
      end else if (kv) begin
        if (m_ndig < D) begin
          m_val = (m_val * 16 + code) % (1 << W);
          m_ndig = m_ndig + 1;
        end else m_ovf = 1;
      end
      m_idle = (kv || ke || !waiting) ? 0 : m_idle + 1;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("num1_hex",       32'(num1_hex),       32'(m_n1));
    chk("num2_hex",       32'(num2_hex),       32'(m_n2));
    chk("operands_valid", 32'(operands_valid), 32'(m_valid));
    chk("shadow_hex",     32'(shadow_hex),     32'(m_val));
    chk("digit_count",    32'(digit_count),    32'(m_ndig));
    chk("entry_state",    32'(entry_state),    32'(m_phase));
    chk("overflow",       32'(overflow),       32'(m_ovf));
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit kv, input int code, input bit ke,
                      input bit kc, input bit ack);
    key_valid = kv; key_code = 4'(code); key_enter = ke;
    key_clear = kc; operands_ack = ack;
    @(posedge clk);
    model_step(kv, code, ke, kc, ack);
    #1;
    key_valid = 1'b0; key_enter = 1'b0; key_clear = 1'b0; operands_ack = 1'b0;
    compare_all();
  endtask

  task automatic digit(input int code); step(1, code, 0, 0, 0); endtask
  task automatic enter();               step(0, 0, 1, 0, 0); endtask
  task automatic clear();               step(0, 0, 0, 1, 0); endtask
  task automatic ack();                 step(0, 0, 0, 0, 1); endtask
  task automatic idle();                step(0, 0, 0, 0, 0); endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_wipe();
    m_ovf = 0;
    compare_all();
    @(negedge clk) rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    key_valid = 0; key_code = 0; key_enter = 0; key_clear = 0; operands_ack = 0;
    model_wipe();
    m_ovf = 0;
    #12;
    compare_all();
    @(negedge clk) rst = 1'b0;

    // 1: two three-digit operands, then ack
    digit(1); digit(2); digit(3); enter();
    digit(4); digit(5); digit(6); enter();
    chk("t1_num1", 32'(num1_hex), 32'h123);
    chk("t1_num2", 32'(num2_hex), 32'h456);
    chk("t1_valid", 32'(operands_valid), 32'd1);
    chk("t1_state", 32'(entry_state), 32'd2);
    ack();
    chk("t1_ack_valid", 32'(operands_valid), 32'd0);
    chk("t1_ack_state", 32'(entry_state), 32'd0);
    chk("t1_keep_num1", 32'(num1_hex), 32'h123);

    // 2: overflow on the fourth digit
    digit(10); digit(11); digit(12); digit(13);
    chk("t2_shadow", 32'(shadow_hex), 32'hABC);
    chk("t2_ovf_pulse", 32'(overflow), 32'd1);
    idle();
    chk("t2_ovf_once", 32'(overflow), 32'd0);
    enter();
    chk("t2_num1", 32'(num1_hex), 32'hABC);
    clear();
    chk("t2_clear_num1", 32'(num1_hex), 32'd0);

    // 3: empty commits, then keys ignored in HOLD
    enter(); enter();
    chk("t3_valid", 32'(operands_valid), 32'd1);
    digit(7);
    chk("t3_hold_shadow", 32'(shadow_hex), 32'd0);
    chk("t3_hold_ovf", 32'(overflow), 32'd0);
    enter();
    chk("t3_hold_enter", 32'(entry_state), 32'd2);
    ack();

    // 4: a digit coinciding with enter is lost
    digit(1); digit(2);
    step(1, 5, 1, 0, 0);
    chk("t4_num1", 32'(num1_hex), 32'h012);
    chk("t4_count", 32'(digit_count), 32'd0);
    clear();

    // 5: idle timeout fires 8 edges after the last strobe
    digit(9);
    for (int i = 0; i < 7; i++) begin
      idle();
      chk("t5_hold_shadow", 32'(shadow_hex), 32'h9);
    end
    idle();
    chk("t5_timeout_shadow", 32'(shadow_hex), 32'd0);
    chk("t5_timeout_count", 32'(digit_count), 32'd0);
    chk("t5_timeout_state", 32'(entry_state), 32'd0);

    // 6: asynchronous reset in ENTRY2, then ack/clear priority in HOLD
    enter(); digit(3); digit(15);
    chk("t6_shadow", 32'(shadow_hex), 32'h3F);
    async_reset();
    digit(1); enter(); digit(2); enter();
    step(0, 0, 0, 1, 1);
    chk("t6_clear_over_ack_num1", 32'(num1_hex), 32'd0);
    digit(4); enter(); digit(8); enter();
    step(1, 6, 0, 0, 1);
    chk("t6_ack_shadow", 32'(shadow_hex), 32'd0);
    chk("t6_ack_num2", 32'(num2_hex), 32'h8);

    // random traffic, including idle stretches long enough to time out
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 45)      step(1, $urandom_range(0, 15), 0, 0, $urandom_range(0, 3) == 0);
      else if (r < 56) step($urandom_range(0, 1), $urandom_range(0, 15), 1, 0, 0);
      else if (r < 59) step($urandom_range(0, 1), $urandom_range(0, 15),
                            $urandom_range(0, 1), 1, 0);
      else if (r < 70) step(0, 0, 0, 0, 1);
      else             idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
